mmio_master: RTL and testbench

MMIO_MASTER -- requirements
Module: mmio_master

---
 rtl/mmio_master.sv | 144 ++++++++++++++
 tb/tb_mmio_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_master.sv
// mmio_master
//   Turns single request/response transactions into one-cycle MMIO bus strobes.
//   Only one transaction is in flight at a time. Reads are abandoned after
//   TIMEOUT cycles in READ_WAIT and complete with resp_error_out=1.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid_in/ready_out   request handshake (ready only in IDLE)
//   req_write_in             1 = write, 0 = read
//   req_addr_in/data_in      request address and write data
//   resp_valid_out/ready_in  response handshake
//   resp_data_out            read data (0 for writes and timeouts)
//   resp_error_out           1 = read timed out
//   addr_out, data_out       bus address / write data, hold between transactions
//   wr_out, rd_out           one-cycle bus strobes
//   rd_valid_in, data_in     peripheral read reply, sampled only in READ_WAIT
module mmio_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_write_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_data_in,
    output logic        resp_valid_out,
    input  logic        resp_ready_in,
    output logic [31:0] resp_data_out,
    output logic        resp_error_out,
    output logic [31:0] addr_out,
    output logic [31:0] data_out,
    output logic        wr_out,
    output logic        rd_out,
    input  logic        rd_valid_in,
    input  logic [31:0] data_in
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        READ_WAIT,
        RESP
    } state_t;

    // Last counter value spent waiting before the read is given up.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] addr_next, data_next, resp_data_next;
    logic        wr_next, rd_next, resp_valid_next, resp_error_next;

    assign req_ready_out = (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 8'd0;
            addr_out       <= 32'd0;
            data_out       <= 32'd0;
            wr_out         <= 1'b0;
            rd_out         <= 1'b0;
            resp_valid_out <= 1'b0;
            resp_data_out  <= 32'd0;
            resp_error_out <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            addr_out       <= addr_next;
            data_out       <= data_next;
            wr_out         <= wr_next;
            rd_out         <= rd_next;
            resp_valid_out <= resp_valid_next;
            resp_data_out  <= resp_data_next;
            resp_error_out <= resp_error_next;
        end
    end

    // Every output is computed one state ahead so it is registered on entry
    // into the state that owns it (strobes in WRITE/READ, response in RESP).
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        addr_next       = addr_out;
        data_next       = data_out;
        wr_next         = 1'b0;
        rd_next         = 1'b0;
        resp_valid_next = resp_valid_out;
        resp_data_next  = resp_data_out;
        resp_error_next = resp_error_out;

        case (state_reg)
            IDLE: begin
                if (req_valid_in) begin
                    addr_next = req_addr_in;
                    if (req_write_in) begin
                        data_next  = req_data_in;
                        wr_next    = 1'b1;
                        state_next = WRITE;
                    end else begin
                        rd_next    = 1'b1;
                        state_next = READ;
                    end
                end
            end
            WRITE: begin
                resp_valid_next = 1'b1;
                resp_data_next  = 32'd0;
                resp_error_next = 1'b0;
                state_next      = RESP;
            end
            READ: begin
                cnt_next   = 8'd0;
                state_next = READ_WAIT;
            end
            READ_WAIT: begin
                // A reply on the final waiting cycle still wins over the timeout.
                if (rd_valid_in) begin
                    resp_valid_next = 1'b1;
                    resp_data_next  = data_in;
                    resp_error_next = 1'b0;
                    state_next      = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    resp_valid_next = 1'b1;
                    resp_data_next  = 32'd0;
                    resp_error_next = 1'b1;
                    state_next      = RESP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            RESP: begin
                if (resp_ready_in) begin
                    resp_valid_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmio_master.sv
// tb_mmio_master
//   Directed bench for mmio_master (TIMEOUT=16). Expected responses are queued
//   when a request is driven and popped when resp_valid_out appears. The bench
//   also plays the peripheral: it stores strobed writes in a small register
//   file and replies to reads on a chosen cycle.
module tb_mmio_master;

    logic        clk;
    logic        rst;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_write_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_data_in;
    logic        resp_valid_out;
    logic        resp_ready_in;
    logic [31:0] resp_data_out;
    logic        resp_error_out;
    logic [31:0] addr_out;
    logic [31:0] data_out;
    logic        wr_out;
    logic        rd_out;
    logic        rd_valid_in;
    logic [31:0] data_in;

    int          n_cmp;
    int          n_fail;
    logic [32:0] sb_q[$];
    logic [32:0] exp_resp;
    logic [31:0] mem [16];

    mmio_master #(.TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_write_in   (req_write_in),
        .req_addr_in    (req_addr_in),
        .req_data_in    (req_data_in),
        .resp_valid_out (resp_valid_out),
        .resp_ready_in  (resp_ready_in),
        .resp_data_out  (resp_data_out),
        .resp_error_out (resp_error_out),
        .addr_out       (addr_out),
        .data_out       (data_out),
        .wr_out         (wr_out),
        .rd_out         (rd_out),
        .rd_valid_in    (rd_valid_in),
        .data_in        (data_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // One full transaction, entered and left at a negedge with resp_ready_in=1.
    // reply_k: cycle (relative to the accept cycle) in which the peripheral
    // replies; late: drive a stray reply while the response is being presented.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input int reply_k, input logic late,
                       input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        int   k;
        logic seen;
        req_valid_in = 1'b1;
        req_write_in = wr;
        req_addr_in  = addr;
        req_data_in  = data;
        chk("req_ready", {31'd0, req_ready_out}, 32'd1);
        sb_q.push_back({exp_err, exp_data});
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 64) begin
            @(negedge clk);
            k++;
            rd_valid_in = 1'b0;
            data_in     = 32'hDEAD_BEEF;
            if (k == 1) begin
                req_valid_in = 1'b0;
                chk(wr ? "wr_strobe" : "rd_strobe", {31'd0, wr ? wr_out : rd_out}, 32'd1);
                chk("strobe_excl", {31'd0, wr ? rd_out : wr_out}, 32'd0);
                chk("addr_out", addr_out, addr);
                if (wr) begin
                    chk("data_out", data_out, data);
                    mem[addr_out[5:2]] = data_out;
                end
            end else begin
                chk("strobe_idle", {30'd0, wr_out, rd_out}, 32'd0);
            end
            if (resp_valid_out) seen = 1'b1;
            else if (k == reply_k) begin
                rd_valid_in = 1'b1;
                data_in     = mem[addr_out[5:2]];
            end
        end
        chk("resp_seen", {31'd0, seen}, 32'd1);
        chk("latency", 32'(k), 32'(exp_lat));
        exp_resp = sb_q.pop_front();
        chk("resp_data", resp_data_out, exp_resp[31:0]);
        chk("resp_error", {31'd0, resp_error_out}, {31'd0, exp_resp[32]});
        $display("txn %s addr=0x%08h data=0x%08h err=%0d latency=%0d",
                 wr ? "WR" : "RD", addr, resp_data_out, resp_error_out, k);
        if (late) begin
            rd_valid_in = 1'b1;
            data_in     = 32'h5555_AAAA;
        end
        @(negedge clk);
        rd_valid_in = 1'b0;
        chk("resp_drop", {31'd0, resp_valid_out}, 32'd0);
        chk("idle_ready", {31'd0, req_ready_out}, 32'd1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[1] = 32'hA5A5_A5A5;

        // Reset with a write offered: reset must win.
        rst           = 1'b1;
        req_valid_in  = 1'b1;
        req_write_in  = 1'b1;
        req_addr_in   = 32'h1234_0000;
        req_data_in   = 32'h0BAD_0BAD;
        resp_ready_in = 1'b1;
        rd_valid_in   = 1'b0;
        data_in       = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_wr_out", {31'd0, wr_out}, 32'd0);
        chk("rst_rd_out", {31'd0, rd_out}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid_out}, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error_out}, 32'd0);
        chk("rst_resp_data", resp_data_out, 32'd0);
        chk("rst_addr_out", addr_out, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready_out}, 32'd1);
        rst          = 1'b0;
        req_valid_in = 1'b0;
        $display("reset done");

        // Basic write and read.
        txn(1'b1, 32'hFFFF_0000, 32'h1234_5678, 0, 1'b0, 32'd0, 1'b0, 2);
        txn(1'b0, 32'hFFFF_0004, 32'd0, 2, 1'b0, 32'hA5A5_A5A5, 1'b0, 3);
        // Timeout, with a stray late reply that must be discarded.
        txn(1'b0, 32'hFFFF_0008, 32'd0, 0, 1'b1, 32'd0, 1'b1, 18);
        // Reply on the final waiting cycle counts as success.
        txn(1'b0, 32'hFFFF_0004, 32'd0, 17, 1'b0, 32'hA5A5_A5A5, 1'b0, 18);
        // Write followed by read-back, and a slower peripheral.
        txn(1'b1, 32'hFFFF_000C, 32'hCAFE_F00D, 0, 1'b0, 32'd0, 1'b0, 2);
        txn(1'b0, 32'hFFFF_000C, 32'd0, 2, 1'b0, 32'hCAFE_F00D, 1'b0, 3);
        txn(1'b0, 32'hFFFF_000C, 32'd0, 5, 1'b0, 32'hCAFE_F00D, 1'b0, 6);

        // Response backpressure with a competing request.
        req_valid_in = 1'b1;
        req_write_in = 1'b1;
        req_addr_in  = 32'hFFFF_0010;
        req_data_in  = 32'h1111_2222;
        sb_q.push_back({1'b0, 32'd0});
        @(negedge clk);
        req_valid_in  = 1'b0;
        resp_ready_in = 1'b0;
        @(negedge clk);
        chk("bp_resp_valid", {31'd0, resp_valid_out}, 32'd1);
        exp_resp = sb_q.pop_front();
        chk("bp_resp_data", resp_data_out, exp_resp[31:0]);
        req_valid_in = 1'b1;
        req_addr_in  = 32'hFFFF_0014;
        req_data_in  = 32'h3333_4444;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, resp_valid_out}, 32'd1);
            chk("bp_hold_data", resp_data_out, 32'd0);
            chk("bp_hold_ready", {31'd0, req_ready_out}, 32'd0);
            chk("bp_no_accept", {31'd0, wr_out}, 32'd0);
        end
        $display("backpressure held 5 cycles");
        resp_ready_in = 1'b1;
        @(negedge clk);
        chk("bp_released", {31'd0, resp_valid_out}, 32'd0);
        chk("bp_ready_again", {31'd0, req_ready_out}, 32'd1);
        sb_q.push_back({1'b0, 32'd0});
        @(negedge clk);
        req_valid_in = 1'b0;
        chk("bp_accept_wr", {31'd0, wr_out}, 32'd1);
        chk("bp_accept_addr", addr_out, 32'hFFFF_0014);
        chk("bp_accept_data", data_out, 32'h3333_4444);
        @(negedge clk);
        chk("bp2_resp_valid", {31'd0, resp_valid_out}, 32'd1);
        exp_resp = sb_q.pop_front();
        chk("bp2_resp_data", resp_data_out, exp_resp[31:0]);
        chk("bp2_resp_error", {31'd0, resp_error_out}, {31'd0, exp_resp[32]});
        $display("txn WR addr=0x%08h accepted after handshake", addr_out);
        @(negedge clk);
        chk("bp2_drop", {31'd0, resp_valid_out}, 32'd0);

        // Reset during READ_WAIT drops the read without a response.
        req_valid_in = 1'b1;
        req_write_in = 1'b0;
        req_addr_in  = 32'hFFFF_0018;
        @(negedge clk);
        req_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_rst_resp_valid", {31'd0, resp_valid_out}, 32'd0);
        chk("rw_rst_rd_out", {31'd0, rd_out}, 32'd0);
        chk("rw_rst_ready", {31'd0, req_ready_out}, 32'd1);
        rd_valid_in = 1'b1;
        data_in     = 32'h7777_8888;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rw_late_ignored", {31'd0, resp_valid_out}, 32'd0);
            chk("rw_still_idle", {31'd0, req_ready_out}, 32'd1);
        end
        rd_valid_in = 1'b0;
        $display("reset in READ_WAIT dropped read");
        txn(1'b1, 32'hFFFF_001C, 32'h9ABC_DEF0, 0, 1'b0, 32'd0, 1'b0, 2);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
